// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the FD/DE/EW pipeline sequencer: run modes, register update codes
// and default widths.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    STOP = 2'd3
  } run_mode_t;

  typedef enum logic [1:0] {
    UPD_HOLD  = 2'b00,
    UPD_ADV   = 2'b01,
    UPD_CLEAR = 2'b10
  } upd_t;

  localparam int LAT_W_DEF  = 5;
  localparam int PERF_W_DEF = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline sequencer (master) and the FD/DE/EW datapath (slave).
// Optional performance counters appear only when PIPE_PERF_EN is defined.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
`ifdef PIPE_PERF_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) ();

  logic             aa_received;
  logic             load_done;
  logic             aa_sent;
  logic [LAT_W-1:0] de_wait_time;
  logic             de_stop;
  logic             uart_busy;
  logic             d_hazard;
  logic             npc_stall;

  run_mode_t        mode;
  upd_t             fd_update;
  upd_t             de_update;
  upd_t             ew_update;
  logic             exec_done;
  logic             e_start;
  logic [LAT_W-1:0] latency;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] perf_cycles;
  logic [PERF_W-1:0] perf_stalls;
  logic [PERF_W-1:0] perf_retired;
`endif

  modport master (
    input  aa_received, load_done, aa_sent, de_wait_time, de_stop,
           uart_busy, d_hazard, npc_stall,
    output mode, fd_update, de_update, ew_update, exec_done, e_start, latency
`ifdef PIPE_PERF_EN
    , output perf_cycles, perf_stalls, perf_retired
`endif
  );

  modport slave (
    output aa_received, load_done, aa_sent, de_wait_time, de_stop,
           uart_busy, d_hazard, npc_stall,
    input  mode, fd_update, de_update, ew_update, exec_done, e_start, latency
`ifdef PIPE_PERF_EN
    , input perf_cycles, perf_stalls, perf_retired
`endif
  );

endinterface

// File: rtl/exec_latency_cnt.sv
// Multi-cycle execute latency counter for the instruction in DE, plus the retire
// compare that produces exec_done.
module exec_latency_cnt #(
  parameter int LAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_exec,
  input  logic [LAT_W-1:0] wait_time,
  input  logic             uart_busy,
  output logic [LAT_W-1:0] latency,
  output logic             exec_done
);

  // ">=" rather than "==" so a wait_time that drops below the count cannot deadlock
  assign exec_done = in_exec & (latency >= wait_time) & ~uart_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latency <= '0;
    end else if (!in_exec || exec_done) begin
      latency <= '0;
    end else if (latency < wait_time) begin
      latency <= latency + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 3-stage FD/DE/EW pipeline: run-mode FSM, execute latency,
// per-register update codes and the execute start strobe. Optional: PIPE_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
`ifdef PIPE_PERF_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.master  bus
);

  run_mode_t        mode_p1;
  logic             e_start_p1;
  logic [LAT_W-1:0] latency;
  logic             exec_done;
  upd_t             fd_upd;
  upd_t             de_upd;
  upd_t             ew_upd;

  exec_latency_cnt #(
    .LAT_W (LAT_W)
  ) u_lat (
    .clk       (clk),
    .rst       (rst),
    .in_exec   (mode_p1 == EXEC),
    .wait_time (bus.de_wait_time),
    .uart_busy (bus.uart_busy),
    .latency   (latency),
    .exec_done (exec_done)
  );

  // Stage p1: run-mode state and the execute start strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p1    <= IDLE;
      e_start_p1 <= 1'b0;
    end else begin
      e_start_p1 <= exec_done;
      case (mode_p1)
        IDLE: if (bus.aa_received) mode_p1 <= LOAD;
        LOAD: if (bus.load_done && bus.aa_sent) mode_p1 <= EXEC;
        EXEC: if (exec_done && bus.de_stop) mode_p1 <= STOP;
        default: mode_p1 <= STOP;
      endcase
    end
  end

  // A hazard with a redirect still advances FD: the fetched pc comes from DE
  always_comb begin
    fd_upd = UPD_HOLD;
    de_upd = UPD_HOLD;
    ew_upd = UPD_HOLD;
    case (mode_p1)
      IDLE, LOAD: begin
        fd_upd = UPD_CLEAR;
        de_upd = UPD_CLEAR;
        ew_upd = UPD_CLEAR;
      end
      EXEC: begin
        if (exec_done) begin
          ew_upd = UPD_ADV;
          fd_upd = (bus.npc_stall || !bus.d_hazard) ? UPD_ADV : UPD_HOLD;
          de_upd = (bus.npc_stall || bus.d_hazard) ? UPD_CLEAR : UPD_ADV;
        end
      end
      default: ;
    endcase
  end

  assign bus.mode      = mode_p1;
  assign bus.fd_update = fd_upd;
  assign bus.de_update = de_upd;
  assign bus.ew_update = ew_upd;
  assign bus.exec_done = exec_done;
  assign bus.e_start   = e_start_p1;
  assign bus.latency   = latency;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] cycles_p1;
  logic [PERF_W-1:0] stalls_p1;
  logic [PERF_W-1:0] retired_p1;

  // Stage p1: performance counters, live only in EXEC so they freeze in STOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_p1  <= '0;
      stalls_p1  <= '0;
      retired_p1 <= '0;
    end else if (mode_p1 == EXEC) begin
      cycles_p1 <= cycles_p1 + 1'b1;
      if (!exec_done || bus.d_hazard)
        stalls_p1 <= stalls_p1 + 1'b1;
      if (exec_done && !bus.d_hazard && !bus.npc_stall)
        retired_p1 <= retired_p1 + 1'b1;
    end
  end

  assign bus.perf_cycles  = cycles_p1;
  assign bus.perf_stalls  = stalls_p1;
  assign bus.perf_retired = retired_p1;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a driver applies directed per-cycle vectors and queues
// the hand-computed outputs; a monitor pops and compares them on the falling edge.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam upd_t H = UPD_HOLD;
  localparam upd_t A = UPD_ADV;
  localparam upd_t C = UPD_CLEAR;

  typedef struct {
    int        row;
    run_mode_t mode;
    upd_t      fd;
    upd_t      de;
    upd_t      ew;
    logic      done;
    logic      es;
    logic [4:0] lat;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   checks;
  int   errors;
  int   row_n;

  pipeline_ctrl_if #(.LAT_W(5)) bus ();

  pipeline_ctrl #(.LAT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL row%0d %s: got %0d expected %0d", row, name, got, want);
    end
  endtask

  // One cycle: apply inputs just after the edge and queue what the outputs must show
  task automatic row(input logic r, input logic aa, input logic ld, input logic sent,
                     input logic [4:0] wt, input logic stop, input logic busy,
                     input logic haz, input logic npc,
                     input run_mode_t m, input upd_t fd, input upd_t de, input upd_t ew,
                     input logic done, input logic es, input logic [4:0] lat);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.aa_received  = aa;
    bus.load_done    = ld;
    bus.aa_sent      = sent;
    bus.de_wait_time = wt;
    bus.de_stop      = stop;
    bus.uart_busy    = busy;
    bus.d_hazard     = haz;
    bus.npc_stall    = npc;
    e.row = row_n; e.mode = m; e.fd = fd; e.de = de; e.ew = ew;
    e.done = done; e.es = es; e.lat = lat;
    sb.push_back(e);
    row_n++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("mode",      e.row, int'(bus.mode),      int'(e.mode));
      chk("fd_update", e.row, int'(bus.fd_update), int'(e.fd));
      chk("de_update", e.row, int'(bus.de_update), int'(e.de));
      chk("ew_update", e.row, int'(bus.ew_update), int'(e.ew));
      chk("exec_done", e.row, int'(bus.exec_done), int'(e.done));
      chk("e_start",   e.row, int'(bus.e_start),   int'(e.es));
      chk("latency",   e.row, int'(bus.latency),   int'(e.lat));
    end
  end

  initial begin
    checks = 0; errors = 0; row_n = 0;
    rst = 1'b1;
    bus.aa_received = 0; bus.load_done = 0; bus.aa_sent = 0; bus.de_wait_time = '0;
    bus.de_stop = 0; bus.uart_busy = 0; bus.d_hazard = 0; bus.npc_stall = 0;

    //   r aa ld sn wt  st bz hz np   mode  fd de ew dn es lat
    row(1, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);
    row(0, 0, 1, 0, 0, 0, 0, 0, 0,  LOAD, C, C, C, 0, 0, 0);
    row(0, 0, 1, 1, 0, 0, 0, 0, 0,  LOAD, C, C, C, 0, 0, 0);
    // wait_time 3: retire on the 4th EXEC cycle
    row(0, 0, 0, 0, 3, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 0);
    row(0, 0, 0, 0, 3, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 1);
    row(0, 0, 0, 0, 3, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 2);
    row(0, 0, 0, 0, 3, 0, 0, 0, 0,  EXEC, A, A, A, 1, 0, 3);
    // single-cycle op blocked by UART for 5 cycles
    row(0, 0, 0, 0, 0, 0, 1, 0, 0,  EXEC, H, H, H, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      row(0, 0, 0, 0, 0, 0, 1, 0, 0, EXEC, H, H, H, 0, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0,  EXEC, A, A, A, 1, 0, 0);
    // hazard bubble, then hazard with redirect
    row(0, 0, 0, 0, 0, 0, 0, 1, 0,  EXEC, H, C, A, 1, 1, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 1,  EXEC, A, C, A, 1, 1, 0);
    // halt with wait_time 2
    row(0, 0, 0, 0, 2, 1, 0, 0, 0,  EXEC, H, H, H, 0, 1, 0);
    row(0, 0, 0, 0, 2, 1, 0, 0, 0,  EXEC, H, H, H, 0, 0, 1);
    row(0, 0, 0, 0, 2, 1, 0, 0, 0,  EXEC, A, A, A, 1, 0, 2);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0,  STOP, H, H, H, 0, 1, 0);
    row(0, 0, 0, 0, 0, 0, 0, 0, 0,  STOP, H, H, H, 0, 0, 0);
`ifdef PIPE_PERF_EN
    chk("perf_cycles",  row_n, int'(bus.perf_cycles),  15);
    chk("perf_stalls",  row_n, int'(bus.perf_stalls),  12);
    chk("perf_retired", row_n, int'(bus.perf_retired), 3);
`endif
    // rerun to EXEC and abort with reset mid-count
    row(1, 0, 0, 0, 0, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);
    row(0, 1, 0, 0, 0, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);
    row(0, 0, 1, 1, 0, 0, 0, 0, 0,  LOAD, C, C, C, 0, 0, 0);
    row(0, 0, 0, 0, 5, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 0);
    row(0, 0, 0, 0, 5, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 1);
    row(0, 0, 0, 0, 5, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 2);
    row(0, 0, 0, 0, 5, 0, 0, 0, 0,  EXEC, H, H, H, 0, 0, 3);
    row(1, 0, 0, 0, 5, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);
    row(0, 0, 0, 0, 5, 0, 0, 0, 0,  IDLE, C, C, C, 0, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
